rx_serial_8n1: RTL and testbench
================================

Name: rx_serial_8n1

Overview:
- UART 8N1 receiver that sits directly upstream of the Polilock control unit.
- Deserialises bytes arriving on the RX pin from the host: opcode characters ("v", "m") and password characters.
- Presents each received byte on `dado_recebido` and issues a one-cycle `pronto` strobe, which drives the control unit's `serial_finished` input.
- Flags framing errors and ignores glitches on the line.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per bit; 50 MHz / 115200 baud. Legal range is 4 to 65535.
- HALF_BIT, CLKS_PER_BIT/2: cycles from the falling edge to the start-bit mid-sample. Derived; do not override.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset: asynchronous, active-high.
- zera  in  1  synchronous clear. Returns to idle, clears `dado_recebido` and `erro_framing`.
- RX  in  1  serial line, asynchronous, idles high.
- dado_recebido  out  8  last correctly framed byte, held until the next good byte or a clear.
- pronto  out  1  one-cycle pulse when a good byte has been received.
- erro_framing  out  1  high after a bad stop bit; sticky until the next good byte, `zera` or `reset`.
- ocupado  out  1  high while a frame is in progress (any state other than idle).
- db_estado  out  4  current state code, for the 7-segment debug display.

Behaviour:
- Reset (asynchronous) values:
  - `dado_recebido` = 0, `pronto` = 0, `erro_framing` = 0, `ocupado` = 0, `db_estado` = 0.
  - Synchroniser flops = 1.
  - Bit counter and tick counter = 0.
- Input synchronisation:
  - RX passes through a 2-FF synchroniser to produce `rx_s`.
  - All decisions use `rx_s`; the 2-cycle synchroniser latency is accepted.
- Tick counter:
  - 16 bits wide, cleared on every state entry.
  - Counts up by 1 each clock in the start, data and stop states.
- State machine (Moore; codes shown in hex):
  - ocioso (0): wait while `rx_s` = 1. When `rx_s` = 0, go to inicio.
  - inicio (1): when tick = HALF_BIT-1, sample `rx_s`.
    - `rx_s` = 0: go to dados, bit index = 0.
    - `rx_s` = 1 (false start/glitch): go to ocioso, no output change.
  - dados (2): when tick = CLKS_PER_BIT-1, shift `rx_s` into the shift register, LSB first, then increment the bit index.
    - After the 8th sample, go to parada.
  - parada (3): when tick = CLKS_PER_BIT-1, sample `rx_s`.
    - `rx_s` = 1: load `dado_recebido` from the shift register, clear `erro_framing`, go to fim.
    - `rx_s` = 0: set `erro_framing`, leave `dado_recebido` unchanged, go to espera_linha.
  - fim (4): `pronto` = 1 for exactly this one cycle, then go to ocioso. A new start bit seen in this cycle is picked up on the next cycle from ocioso.
  - espera_linha (5): stay until `rx_s` = 1, then go to ocioso. This prevents a stuck-low line or a break condition from being read as repeated frames. No `pronto` is issued.
  - Undefined state codes: go to ocioso.
- Latency: `pronto` rises exactly 1 cycle after the stop-bit sample edge.
- Data stability: `dado_recebido` is valid on and after the `pronto` cycle, and is stable until the next `pronto`. The control unit may latch it in the cycle after `pronto` (its grava state).
- `zera` (synchronous): overrides everything. Next state is ocioso, the shift register is cleared, `dado_recebido` = 0, `erro_framing` = 0. If `zera` and the stop-bit sample occur in the same cycle, `zera` wins and no `pronto` is issued.
- Reset mid-frame: the partial frame is discarded.
  - If RX is still low when reset is released, that low level is treated as a new start bit; the frame is then lost via the framing path.
- Back-to-back frames: a start bit immediately following the stop bit is received with no lost bytes. The stop bit costs only 1 extra cycle (fim), so there is no overrun.
- `ocupado` = 1 in states 1 to 5.

Test Plan (CLKS_PER_BIT = 16 unless noted):
- Send 0x76 ("v") with a correct stop bit → exactly one `pronto` pulse, `dado_recebido` = 0x76, `erro_framing` = 0. `pronto` rises 1 cycle after the stop-sample edge, which is (8+0.5+1)×16+2 cycles after RX falls, ±1.
- Send 0x6D ("m") immediately followed by 0x31 with no idle gap → two `pronto` pulses, values 0x6D then 0x31. `dado_recebido` holds 0x6D until the second pulse.
- Hold RX low for 3 cycles, then high → back to ocioso, no `pronto`, `dado_recebido` unchanged, `db_estado` returns to 0.
- Send 0x55 with stop bit = 0, hold RX low for 40 cycles, then send 0x41 correctly → `erro_framing` = 1, no `pronto`, `db_estado` = 5 while the line is low. Then `pronto` fires with 0x41 and `erro_framing` clears.
- Assert `reset` during bit 4 of 0xA5, then send 0x3C → all outputs 0 during reset, no `pronto` for 0xA5, then `pronto` with 0x3C.
- Assert `zera` in the same cycle as the stop-bit sample of 0x7F → no `pronto`, `dado_recebido` = 0, state = ocioso. Repeat the 0x7F test with CLKS_PER_BIT = 434 as a sanity check of the timing margins.

Source files
------------

// File: rtl/rx_serial_8n1_if.sv
// Received-byte bundle of the 8N1 serial receiver: the byte, its strobe,
// the framing-error flag and the debug/status signals.
interface rx_serial_8n1_if;
    logic [7:0] dado_recebido;
    logic       pronto;
    logic       erro_framing;
    logic       ocupado;
    logic [3:0] db_estado;

    // Receiver side drives everything.
    modport master (
        output dado_recebido,
        output pronto,
        output erro_framing,
        output ocupado,
        output db_estado
    );

    // Consumer side (control unit, debug display) only observes.
    modport slave (
        input dado_recebido,
        input pronto,
        input erro_framing,
        input ocupado,
        input db_estado
    );
endinterface

// File: rtl/rx_serial_8n1.sv
// UART 8N1 receiver feeding the Polilock control unit. Samples the start bit
// at its middle, then every data/stop bit one bit period later, presents each
// well-framed byte with a one-cycle `pronto` strobe and flags bad stop bits.
module rx_serial_8n1 #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            zera,
    input  logic            RX,
    rx_serial_8n1_if.master rx_if
);

    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [3:0] {
        OCIOSO       = 4'h0,
        INICIO       = 4'h1,
        DADOS        = 4'h2,
        PARADA       = 4'h3,
        FIM          = 4'h4,
        ESPERA_LINHA = 4'h5
    } estado_t;

    estado_t     estado;
    estado_t     estado_prox;
    logic        rx_meta;
    logic        rx_s;
    logic [15:0] tick;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic [7:0]  dado_q;
    logic        erro_q;
    logic        fim_bit;

    // A tick counter reaching the last cycle of a bit period marks the sample point.
    assign fim_bit = (tick == BIT_LAST);

    // Two-flop synchroniser; flops reset to the idle (high) line level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old
            // values, giving a real two-stage chain instead of one wire.
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // Next-state logic; zera overrides every transition.
    always_comb begin
        // NOTE: defaulting first means no path leaves estado_prox unassigned,
        // so no latch is inferred.
        estado_prox = estado;
        case (estado)
            OCIOSO:       if (!rx_s) estado_prox = INICIO;
            INICIO:       if (tick == HALF_LAST) estado_prox = rx_s ? OCIOSO : DADOS;
            DADOS:        if (fim_bit && bit_idx == 3'd7) estado_prox = PARADA;
            PARADA:       if (fim_bit) estado_prox = rx_s ? FIM : ESPERA_LINHA;
            FIM:          estado_prox = OCIOSO;
            ESPERA_LINHA: if (rx_s) estado_prox = OCIOSO;
            default:      estado_prox = OCIOSO;
        endcase
        if (zera) begin
            estado_prox = OCIOSO;
        end
    end

    // Tick counter: restarts on every state entry and at each data-bit sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick <= '0;
        end else if (zera || estado_prox != estado || (estado == DADOS && fim_bit)) begin
            tick <= '0;
        end else if (estado == INICIO || estado == DADOS || estado == PARADA) begin
            tick <= tick + 16'd1;
        end else begin
            tick <= '0;
        end
    end

    // Bit index and LSB-first shift register for the data bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_idx   <= '0;
            shift_reg <= '0;
        end else if (zera) begin
            bit_idx   <= '0;
            shift_reg <= '0;
        end else if (estado == INICIO) begin
            bit_idx   <= '0;
        end else if (estado == DADOS && fim_bit) begin
            bit_idx   <= bit_idx + 3'd1;
            shift_reg <= {rx_s, shift_reg[7:1]};
        end
    end

    // Stop-bit verdict: load the byte on a good stop bit, flag a bad one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dado_q <= '0;
            erro_q <= 1'b0;
        end else if (zera) begin
            dado_q <= '0;
            erro_q <= 1'b0;
        end else if (estado == PARADA && fim_bit) begin
            if (rx_s) begin
                dado_q <= shift_reg;
                erro_q <= 1'b0;
            end else begin
                erro_q <= 1'b1;
            end
        end
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        rx_if.dado_recebido = dado_q;
        rx_if.erro_framing  = erro_q;
        rx_if.pronto        = (estado == FIM);
        rx_if.ocupado       = (estado != OCIOSO);
        rx_if.db_estado     = estado;
    end

endmodule

// File: tb/tb_rx_serial_8n1.sv
// Directed bench for rx_serial_8n1: one instance at 16 clocks/bit for the
// functional cases, one at 434 clocks/bit for the full-rate zera case.
module tb_rx_serial_8n1;

    localparam int CLKS_A = 16;
    localparam int CLKS_B = 434;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic zera_a = 1'b0;
    logic zera_b = 1'b0;
    logic rx_a   = 1'b1;
    logic rx_b   = 1'b1;

    rx_serial_8n1_if if_a ();
    rx_serial_8n1_if if_b ();

    rx_serial_8n1 #(.CLKS_PER_BIT(CLKS_A)) dut_a (
        .clock (clock),
        .reset (reset),
        .zera  (zera_a),
        .RX    (rx_a),
        .rx_if (if_a.master)
    );

    rx_serial_8n1 #(.CLKS_PER_BIT(CLKS_B)) dut_b (
        .clock (clock),
        .reset (reset),
        .zera  (zera_b),
        .RX    (rx_b),
        .rx_if (if_b.master)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Pronto monitor, sampled on the falling edge; counts every high cycle.
    int         n_pronto_a = 0;
    int         n_pronto_b = 0;
    int         cyc_pronto_a = 0;
    int         cyc_pronto_b = 0;
    logic [7:0] last_a = 8'h00;
    logic [7:0] prev_a = 8'h00;
    always @(negedge clock) begin
        if (if_a.pronto) begin
            n_pronto_a   <= n_pronto_a + 1;
            cyc_pronto_a <= cyc;
            prev_a       <= last_a;
            last_a       <= if_a.dado_recebido;
        end
        if (if_b.pronto) begin
            n_pronto_b   <= n_pronto_b + 1;
            cyc_pronto_b <= cyc;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive(input bit sel_b, input logic v);
        if (sel_b) rx_b = v;
        else       rx_a = v;
    endtask

    // Sends start, 8 data bits LSB first and the given stop level; optionally
    // raises zera for exactly the cycle that ends on the stop-bit sample edge.
    task automatic send_byte(input bit sel_b, input logic [7:0] d, input logic stop,
                             input bit zera_stop, output int t_fall);
        int clks;
        clks = sel_b ? CLKS_B : CLKS_A;
        drive(sel_b, 1'b0);
        t_fall = cyc;
        tick(clks);
        for (int i = 0; i < 8; i++) begin
            drive(sel_b, d[i]);
            tick(clks);
        end
        drive(sel_b, stop);
        if (zera_stop) begin
            tick(clks / 2 + 2);
            if (sel_b) zera_b = 1'b1;
            else       zera_a = 1'b1;
            tick(1);
            zera_a = 1'b0;
            zera_b = 1'b0;
            tick(clks - clks / 2 - 3);
        end else begin
            tick(clks);
        end
    endtask

    initial begin
        int         t;
        int         base;
        logic [7:0] a5;

        // Reset state.
        tick(3);
        check("rst_dado",    32'(if_a.dado_recebido), 32'h00);
        check("rst_pronto",  32'(if_a.pronto),        32'h0);
        check("rst_erro",    32'(if_a.erro_framing),  32'h0);
        check("rst_ocupado", 32'(if_a.ocupado),       32'h0);
        check("rst_estado",  32'(if_a.db_estado),     32'h0);
        reset = 1'b0;
        tick(5);

        // 0x76 with a good stop bit; pronto 155 cycles after RX falls.
        base = n_pronto_a;
        send_byte(1'b0, 8'h76, 1'b1, 1'b0, t);
        tick(4);
        check("v_count",   32'(n_pronto_a - base),   32'd1);
        check("v_data",    32'(last_a),              32'h76);
        check("v_latency", 32'(cyc_pronto_a - t),    32'd155);
        check("v_erro",    32'(if_a.erro_framing),   32'h0);
        check("v_estado",  32'(if_a.db_estado),      32'h0);

        // 0x6D then 0x31 back to back; 0x6D held through the second frame.
        base = n_pronto_a;
        send_byte(1'b0, 8'h6D, 1'b1, 1'b0, t);
        fork
            begin
                int t2;
                send_byte(1'b0, 8'h31, 1'b1, 1'b0, t2);
            end
            begin
                tick(80);
                check("b2b_hold",      32'(if_a.dado_recebido), 32'h6D);
                check("b2b_mid_count", 32'(n_pronto_a - base),  32'd1);
            end
        join
        tick(4);
        check("b2b_count",  32'(n_pronto_a - base), 32'd2);
        check("b2b_first",  32'(prev_a),            32'h6D);
        check("b2b_second", 32'(last_a),            32'h31);

        // 3-cycle glitch: enters inicio, falls back to ocioso with no output.
        base = n_pronto_a;
        rx_a = 1'b0;
        tick(3);
        check("glitch_inicio", 32'(if_a.db_estado), 32'h1);
        rx_a = 1'b1;
        tick(20);
        check("glitch_estado", 32'(if_a.db_estado),     32'h0);
        check("glitch_count",  32'(n_pronto_a - base),  32'd0);
        check("glitch_dado",   32'(if_a.dado_recebido), 32'h31);

        // 0x55 with a bad stop bit and the line left low, then 0x41.
        base = n_pronto_a;
        send_byte(1'b0, 8'h55, 1'b0, 1'b0, t);
        check("ferr_estado", 32'(if_a.db_estado),    32'h5);
        check("ferr_erro",   32'(if_a.erro_framing), 32'h1);
        tick(40);
        check("ferr_stuck",  32'(if_a.db_estado),     32'h5);
        check("ferr_count",  32'(n_pronto_a - base),  32'd0);
        check("ferr_dado",   32'(if_a.dado_recebido), 32'h31);
        rx_a = 1'b1;
        tick(10);
        check("ferr_idle",   32'(if_a.db_estado),    32'h0);
        check("ferr_sticky", 32'(if_a.erro_framing), 32'h1);
        send_byte(1'b0, 8'h41, 1'b1, 1'b0, t);
        tick(4);
        check("ferr_rec_count", 32'(n_pronto_a - base),   32'd1);
        check("ferr_rec_data",  32'(last_a),              32'h41);
        check("ferr_rec_erro",  32'(if_a.erro_framing),   32'h0);

        // Reset during bit 4 of 0xA5, then 0x3C.
        base = n_pronto_a;
        a5 = 8'hA5;
        rx_a = 1'b0;
        tick(CLKS_A);
        for (int i = 0; i < 4; i++) begin
            rx_a = a5[i];
            tick(CLKS_A);
        end
        rx_a = a5[4];
        tick(CLKS_A / 2);
        check("rstmid_ocupado", 32'(if_a.ocupado), 32'h1);
        reset = 1'b1;
        #2;
        check("rstmid_dado",    32'(if_a.dado_recebido), 32'h00);
        check("rstmid_ocup0",   32'(if_a.ocupado),       32'h0);
        check("rstmid_estado",  32'(if_a.db_estado),     32'h0);
        check("rstmid_pronto",  32'(if_a.pronto),        32'h0);
        rx_a = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(20);
        check("rstmid_count", 32'(n_pronto_a - base), 32'd0);
        send_byte(1'b0, 8'h3C, 1'b1, 1'b0, t);
        tick(4);
        check("rstmid_rec_count", 32'(n_pronto_a - base),   32'd1);
        check("rstmid_rec_data",  32'(if_a.dado_recebido),  32'h3C);

        // zera on the stop-bit sample of 0x7F (16 clocks/bit).
        base = n_pronto_a;
        send_byte(1'b0, 8'h7F, 1'b1, 1'b0, t);
        tick(4);
        check("zera_pre_data", 32'(if_a.dado_recebido), 32'h7F);
        send_byte(1'b0, 8'h7F, 1'b1, 1'b1, t);
        tick(4);
        check("zera_count",  32'(n_pronto_a - base),   32'd1);
        check("zera_dado",   32'(if_a.dado_recebido),  32'h00);
        check("zera_estado", 32'(if_a.db_estado),      32'h0);

        // Same at 434 clocks/bit; pronto 3+217+9*434 = 4126 cycles after RX falls.
        send_byte(1'b1, 8'h7F, 1'b1, 1'b0, t);
        tick(4);
        check("b_count",   32'(n_pronto_b),          32'd1);
        check("b_data",    32'(if_b.dado_recebido),  32'h7F);
        check("b_latency", 32'(cyc_pronto_b - t),    32'd4126);
        send_byte(1'b1, 8'h7F, 1'b1, 1'b1, t);
        tick(4);
        check("b_zera_count",  32'(n_pronto_b),         32'd1);
        check("b_zera_dado",   32'(if_b.dado_recebido), 32'h00);
        check("b_zera_estado", 32'(if_b.db_estado),     32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
